wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback arbiter feeding the single register-file write port (w_enable/w_addr/w_data).
//  Merges two result sources:
//    - port A: the in-order pipeline writeback. Fixed priority, never stalled.
//    - port B: long-latency unit results (mul/div, late loads). Buffered in a DEPTH-entry FIFO
//      behind a valid/ready handshake.
//  Also exposes a pending-register query so decode can stall on registers still queued in the FIFO.
// PARAMETERS
//  DEPTH      2   port-B FIFO entries, power of two, >=2
//  ADDR_W     5   register id width (regid_t)
//  DATA_W     32  data width (word_t)
//  CNT_W      16  starvation counter width
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  a_valid    in   1        pipeline writeback valid
//  a_addr     in   ADDR_W   pipeline destination register
//  a_data     in   DATA_W   pipeline result
//  b_valid    in   1        long-latency result valid
//  b_ready    out  1        FIFO can accept; transfer when b_valid&&b_ready
//  b_addr     in   ADDR_W   long-latency destination register
//  b_data     in   DATA_W   long-latency result
//  q_addr     in   ADDR_W   decode query register id
//  q_pending  out  1        q_addr matches a valid FIFO entry (combinational)
//  w_enable   out  1        register-file write enable (registered)
//  w_addr     out  ADDR_W   register-file write address (registered)
//  w_data     out  DATA_W   register-file write data (registered)
//  starve_cnt out  CNT_W    cycles FIFO non-empty while A won (saturating)
// BEHAVIOUR
//  Reset (rst high at posedge):
//    - count, rd_ptr, wr_ptr = 0.
//    - w_enable = 0, w_addr = 0, w_data = 0, starve_cnt = 0.
//    - b_ready = 0 while rst is high; FIFO contents are discarded.
//  b_ready = (count != DEPTH), from registered count only. A same-cycle pop never frees a slot for a push.
//  Selection per cycle (grant is combinational, result registered):
//    - a_valid=1: A wins; FIFO head held.
//    - a_valid=0 and count>0: FIFO head wins and is popped.
//    - otherwise: idle, w_enable<=0.
//  Latency:
//    - A at cycle t -> w_* at t+1.
//    - B accepted at t -> head no earlier than t+1 -> w_* at t+2 minimum.
//    - No bypass from b_* to w_*.
//  Register zero: a granted source with addr==0 is consumed (FIFO pops) but drives w_enable<=0.
//    w_addr/w_data still update.
//  Push and pop in the same cycle: count unchanged; both pointers advance.
//    Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//  Ordering: FIFO entries are written in acceptance order. A and B are not reordered relative to each
//    other by this block; decode stalls on q_pending to avoid WAW hazards.
//  q_pending:
//    - OR over valid entries of (entry.addr == q_addr); 0 when q_addr==0.
//    - An entry popped this cycle still counts until the edge.
//  starve_cnt: +1 each cycle with a_valid && count>0; saturates at all-ones.
//  Reset mid-operation: queued entries are never written. The cycle after rst deasserts, w_enable is 0.
// TESTING
//  1. Reset: rst high 2 cycles with b_valid=1 -> w_enable=0, b_ready=0, nothing accepted.
//     After release: b_ready=1, q_pending=0, starve_cnt=0.
//  2. A only: a_valid, a_addr=5, a_data=32'hDEADBEEF at t -> w_enable=1, w_addr=5,
//     w_data=32'hDEADBEEF at t+1; w_enable=0 at t+2.
//  3. B only: accept addr=7, data=32'h11 at t -> q_pending(7)=1 during t+1 only;
//     w_enable=1, w_addr=7, w_data=32'h11 at t+2.
//  4. Conflict/full: push B addr 3 then 4 (DEPTH=2) while a_valid held 4 cycles ->
//     - b_ready=0 once count=2; A writes appear each cycle; starve_cnt=3.
//     - After A drops: writes addr 3 then addr 4 on consecutive cycles.
//  5. Register zero: a_valid with addr 0, then B push with addr 0 -> w_enable never 1;
//     FIFO count returns to 0.
//  6. Reset mid-op: FIFO holds 2 entries, a_valid=0, rst pulsed 1 cycle -> neither entry is written;
//     count=0, b_ready=1 the cycle after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline result (A), long-latency result (B),
// pending-register query and the register-file write port.
interface wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] q_addr;
  logic              q_pending;
  logic              w_enable;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  starve_cnt;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    output b_ready, q_pending, w_enable, w_addr, w_data, starve_cnt
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    input  b_ready, q_pending, w_enable, w_addr, w_data, starve_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: the pipeline (A) always wins the register-file port; long-latency
// results (B) wait in a small FIFO that drains whenever A is idle.
module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_F = PTR_W + 1;
  localparam logic [CNT_F-1:0] FULL = CNT_F'(DEPTH);

  typedef logic [ADDR_W-1:0] regid_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    regid_t addr;
    word_t  data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_F-1:0]  count;
  logic              push, pop;
  entry_t            head;
  logic              q_hit;

  logic              w_enable_q;
  regid_t            w_addr_q;
  word_t             w_data_q;
  logic [CNT_W-1:0]  starve_q;

  // Ready looks only at the registered count, so a pop never makes room for a same-cycle push.
  assign bus.b_ready = !rst && (count != FULL);
  assign push        = bus.b_valid && bus.b_ready;
  assign pop         = !bus.a_valid && (count != '0);
  assign head        = mem[rd_ptr];

  // An entry is live when its distance from rd_ptr is below count; wrap is free since DEPTH is 2^n.
  always_comb begin
    logic [PTR_W-1:0] off;
    q_hit = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (({1'b0, off} < count) && (mem[i].addr == bus.q_addr))
        q_hit = 1'b1;
    end
  end

  assign bus.q_pending = q_hit && (bus.q_addr != '0);

  // NOTE: FIFO storage has no reset; count/pointers define which slots are live,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: bus.b_addr, data: bus.b_data};
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Register zero is consumed like any other destination but never enables a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
    end else if (bus.a_valid) begin
      w_enable_q <= (bus.a_addr != '0);
      w_addr_q   <= bus.a_addr;
      w_data_q   <= bus.a_data;
    end else if (pop) begin
      w_enable_q <= (head.addr != '0);
      w_addr_q   <= head.addr;
      w_data_q   <= head.data;
    end else begin
      w_enable_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      starve_q <= '0;
    else if (bus.a_valid && (count != '0) && (starve_q != '1))
      starve_q <= starve_q + 1'b1;
  end

  assign bus.w_enable   = w_enable_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.w_data     = w_data_q;
  assign bus.starve_cnt = starve_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, A-only, B-only, conflict/full,
// register zero and reset in mid-operation.
module tb_wb_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  wb_arbiter #(.DEPTH(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.q_addr  = '0;
  endtask

  task automatic exp_w(input string name, input logic en, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input bit chk_payload);
    checks++;
    if (bus.w_enable !== en) begin
      errors++;
      $display("FAIL %s w_enable: got %0b expected %0b", name, bus.w_enable, en);
    end
    if (chk_payload) begin
      checks++;
      if (bus.w_addr !== addr || bus.w_data !== data) begin
        errors++;
        $display("FAIL %s w_addr/w_data: got %0d/%08h expected %0d/%08h",
                 name, bus.w_addr, bus.w_data, addr, data);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h99;
    step();
    step();
    exp_w("reset", 1'b0, '0, '0, 1'b1);
    checks++;
    if (bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL reset b_ready: got %0b expected 0", bus.b_ready);
    end
    rst = 1'b0;
    bus.b_valid = 1'b0;
    bus.q_addr = 5'd9;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL release b_ready: got %0b expected 1", bus.b_ready);
    end
    checks++;
    if (bus.q_pending !== 1'b0) begin
      errors++; $display("FAIL release q_pending: got %0b expected 0", bus.q_pending);
    end
    checks++;
    if (bus.starve_cnt !== '0) begin
      errors++; $display("FAIL release starve_cnt: got %0d expected 0", bus.starve_cnt);
    end
    step();
    exp_w("release_nothing_queued", 1'b0, '0, '0, 1'b0);
    step();
    exp_w("release_nothing_queued2", 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_a_only();
    idle_inputs();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    step();
    bus.a_valid = 1'b0;
    exp_w("a_only_t1", 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    step();
    exp_w("a_only_t2", 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_b_only();
    idle_inputs();
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h11;
    bus.q_addr = 5'd7;
    #1;
    checks++;
    if (bus.q_pending !== 1'b0) begin
      errors++; $display("FAIL b_only q_pending_t: got %0b expected 0", bus.q_pending);
    end
    step();
    bus.b_valid = 1'b0;
    #1;
    checks++;
    if (bus.q_pending !== 1'b1) begin
      errors++; $display("FAIL b_only q_pending_t1: got %0b expected 1", bus.q_pending);
    end
    exp_w("b_only_no_bypass", 1'b0, '0, '0, 1'b0);
    step();
    checks++;
    if (bus.q_pending !== 1'b0) begin
      errors++; $display("FAIL b_only q_pending_t2: got %0b expected 0", bus.q_pending);
    end
    exp_w("b_only_t2", 1'b1, 5'd7, 32'h11, 1'b1);
    step();
    exp_w("b_only_t3", 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_conflict_full();
    idle_inputs();
    bus.a_valid = 1'b1; bus.a_addr = 5'd10; bus.a_data = 32'hA0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd3;  bus.b_data = 32'h33;
    step();
    exp_w("conflict_a0", 1'b1, 5'd10, 32'hA0, 1'b1);
    bus.a_addr = 5'd11; bus.a_data = 32'hA1;
    bus.b_addr = 5'd4;  bus.b_data = 32'h44;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL conflict b_ready_cnt1: got %0b expected 1", bus.b_ready);
    end
    step();
    bus.b_valid = 1'b0;
    exp_w("conflict_a1", 1'b1, 5'd11, 32'hA1, 1'b1);
    checks++;
    if (bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL conflict b_ready_full: got %0b expected 0", bus.b_ready);
    end
    bus.a_addr = 5'd12; bus.a_data = 32'hA2;
    step();
    exp_w("conflict_a2", 1'b1, 5'd12, 32'hA2, 1'b1);
    bus.a_addr = 5'd13; bus.a_data = 32'hA3;
    step();
    exp_w("conflict_a3", 1'b1, 5'd13, 32'hA3, 1'b1);
    checks++;
    if (bus.starve_cnt !== 16'd3) begin
      errors++; $display("FAIL conflict starve_cnt: got %0d expected 3", bus.starve_cnt);
    end
    bus.a_valid = 1'b0;
    bus.q_addr = 5'd4;
    #1;
    checks++;
    if (bus.q_pending !== 1'b1) begin
      errors++; $display("FAIL conflict q_pending4: got %0b expected 1", bus.q_pending);
    end
    step();
    exp_w("drain_first", 1'b1, 5'd3, 32'h33, 1'b1);
    step();
    exp_w("drain_second", 1'b1, 5'd4, 32'h44, 1'b1);
    checks++;
    if (bus.starve_cnt !== 16'd3 || bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain starve/b_ready: got %0d/%0b expected 3/1", bus.starve_cnt, bus.b_ready);
    end
    step();
    exp_w("drain_idle", 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reg_zero();
    idle_inputs();
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h55;
    step();
    bus.a_valid = 1'b0;
    exp_w("zero_a", 1'b0, 5'd0, 32'h55, 1'b1);
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h66;
    bus.q_addr = 5'd0;
    step();
    bus.b_valid = 1'b0;
    checks++;
    if (bus.q_pending !== 1'b0) begin
      errors++; $display("FAIL zero q_pending: got %0b expected 0", bus.q_pending);
    end
    exp_w("zero_b_queued", 1'b0, 5'd0, 32'h55, 1'b1);
    step();
    exp_w("zero_b_popped", 1'b0, 5'd0, 32'h66, 1'b1);
    // Two fresh pushes must both be accepted if the FIFO really emptied.
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd20; bus.b_data = 32'h20;
    step();
    bus.b_addr = 5'd21; bus.b_data = 32'h21;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL zero count_empty b_ready: got %0b expected 1", bus.b_ready);
    end
    step();
    bus.b_valid = 1'b0;
    checks++;
    if (bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL zero refill b_ready: got %0b expected 0", bus.b_ready);
    end
  endtask

  // Entered with FIFO holding addr 20 and 21 and a_valid still high.
  task automatic test_reset_midop();
    bus.a_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.q_addr = 5'd20;
    #1;
    exp_w("midop_reset", 1'b0, '0, '0, 1'b1);
    checks++;
    if (bus.b_ready !== 1'b1 || bus.q_pending !== 1'b0) begin
      errors++;
      $display("FAIL midop b_ready/q_pending: got %0b/%0b expected 1/0", bus.b_ready, bus.q_pending);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      exp_w("midop_no_write", 1'b0, '0, '0, 1'b0);
    end
    checks++;
    if (bus.starve_cnt !== '0) begin
      errors++; $display("FAIL midop starve_cnt: got %0d expected 0", bus.starve_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_a_only();
    test_b_only();
    test_conflict_full();
    test_reg_zero();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
